// File: rtl/subleq_core_p.sv
// SUBLEQ processor core: mem[B] -= mem[A]; branch to C when the result is <= 0.
// Talks to a single-port RAM over a req/ack handshake and tolerates any number of wait states.
module subleq_core_p #(
    parameter int unsigned         DATA_W    = 8,
    parameter int unsigned         ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [ADDR_W-1:0]   HALT_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned         CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_halt_req,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_busy,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc,
    output logic [CNT_W-1:0]  o_icount
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FA,
        S_FB,
        S_FC,
        S_LA,
        S_LB,
        S_EX,
        S_WR,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [ADDR_W-1:0]   rb_q, rb_d;
    logic [ADDR_W-1:0]   rc_q, rc_d;
    logic [DATA_W-1:0]   va_q, va_d;
    logic [DATA_W-1:0]   vb_q, vb_d;
    logic [DATA_W-1:0]   diff_q, diff_d;
    logic                leq_q, leq_d;
    logic [ADDR_W-1:0]   npc_q, npc_d;
    logic [CNT_W-1:0]    icount_q, icount_d;
    logic                halted_q, halted_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    // State and datapath registers; reset abandons any pending access at once.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ra_q        <= '0;
            rb_q        <= '0;
            rc_q        <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            diff_q      <= '0;
            leq_q       <= 1'b0;
            npc_q       <= '0;
            icount_q    <= '0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rc_q        <= rc_d;
            va_q        <= va_d;
            vb_q        <= vb_d;
            diff_q      <= diff_d;
            leq_q       <= leq_d;
            npc_q       <= npc_d;
            icount_q    <= icount_d;
            halted_q    <= halted_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, datapath updates, and the bus outputs for the state being entered.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rc_d        = rc_q;
        va_d        = va_q;
        vb_d        = vb_q;
        diff_d      = diff_q;
        leq_d       = leq_q;
        npc_d       = npc_q;
        icount_d    = icount_q;
        halted_d    = halted_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = 1'b1;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    pc_d     = RESET_PC;
                    icount_d = '0;
                    halted_d = 1'b0;
                    state_d  = S_FA;
                end
            end
            S_FA: begin
                if (i_mem_ack) begin
                    ra_d    = i_mem_rdata[ADDR_W-1:0];
                    state_d = S_FB;
                end
            end
            S_FB: begin
                if (i_mem_ack) begin
                    rb_d    = i_mem_rdata[ADDR_W-1:0];
                    state_d = S_FC;
                end
            end
            S_FC: begin
                if (i_mem_ack) begin
                    rc_d    = i_mem_rdata[ADDR_W-1:0];
                    state_d = S_LA;
                end
            end
            S_LA: begin
                if (i_mem_ack) begin
                    va_d    = i_mem_rdata;
                    state_d = S_LB;
                end
            end
            S_LB: begin
                if (i_mem_ack) begin
                    vb_d    = i_mem_rdata;
                    state_d = S_EX;
                end
            end
            S_EX: begin
                diff_d  = vb_q - va_q;
                leq_d   = diff_d[DATA_W-1] | (diff_d == '0);
                npc_d   = leq_d ? rc_q : pc_q + ADDR_W'(3);
                state_d = S_WR;
            end
            S_WR: begin
                if (i_mem_ack) begin
                    pc_d = npc_q;
                    if (icount_q != {CNT_W{1'b1}}) begin
                        icount_d = icount_q + CNT_W'(1);
                    end
                    if (leq_q && (rc_q == HALT_ADDR)) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else if (i_halt_req) begin
                        halted_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_FA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address/data only change on entry to a state, so they stay put while an ack is awaited.
        case (state_d)
            S_FA: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end
            S_FB: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d + ADDR_W'(1);
            end
            S_FC: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d + ADDR_W'(2);
            end
            S_LA: begin
                mem_req_d  = 1'b1;
                mem_addr_d = ra_d;
            end
            S_LB: begin
                mem_req_d  = 1'b1;
                mem_addr_d = rb_d;
            end
            S_WR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = rb_d;
                mem_wdata_d = diff_d;
            end
            S_IDLE, S_HALTED: busy_d = 1'b0;
            default: ;
        endcase
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_busy      = busy_q;
    assign o_halted    = halted_q;
    assign o_pc        = pc_q;
    assign o_icount    = icount_q;

endmodule

// File: tb/tb_subleq_core_p.sv
// Bench for subleq_core_p: a RAM responder with configurable wait states and an
// instruction-level SUBLEQ reference model that checks every retired instruction.
module tb_subleq_core_p;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] icount;

    subleq_core_p dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_halt_req  (halt_req),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_busy      (busy),
        .o_halted    (halted),
        .o_pc        (pc),
        .o_icount    (icount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0]  dut_mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_pc;
    logic [15:0] ref_cnt;
    logic        ref_halted;
    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];
    int          wait_cfg = 0;
    bit          spurious = 1'b1;

    // RAM responder: acks after wait_cfg stall cycles, checks bus hold, throws stray acks when idle.
    int          wait_cnt = 0;
    logic [7:0]  p_addr, p_wdata;
    logic        p_we;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt > 0) begin
                check("hold_addr", 32'(mem_addr), 32'(p_addr));
                check("hold_we", 32'(mem_we), 32'(p_we));
                if (p_we) check("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
            end else begin
                p_addr  = mem_addr;
                p_we    = mem_we;
                p_wdata = mem_wdata;
            end
            if (wait_cnt >= wait_cfg) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    dut_mem[mem_addr] = mem_wdata;
                    wr_q.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_rdata = dut_mem[mem_addr];
                    rd_q.push_back(mem_addr);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (spurious && $urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'($urandom);
            end
        end
    end

    int last_cyc;

    // Reference: execute one SUBLEQ instruction on ref_mem and compare with the DUT's bus and state.
    task automatic step(input int w);
        logic [7:0]  a, b, c, p1, p2, diff, exp_rd [5];
        logic [15:0] wr;
        bit          taken;
        p1    = ref_pc + 8'd1;
        p2    = ref_pc + 8'd2;
        a     = ref_mem[ref_pc];
        b     = ref_mem[p1];
        c     = ref_mem[p2];
        diff  = ref_mem[b] - ref_mem[a];
        taken = ($signed(diff) <= 0);
        exp_rd[0] = ref_pc; exp_rd[1] = p1; exp_rd[2] = p2; exp_rd[3] = a; exp_rd[4] = b;
        check("n_reads", rd_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (rd_q.size() > 0) check("rd_addr", 32'(rd_q.pop_front()), 32'(exp_rd[i]));
        rd_q.delete();
        wr = wr_q.pop_front();
        check("wr_addr", 32'(wr[15:8]), 32'(b));
        check("wr_data", 32'(wr[7:0]), 32'(diff));
        ref_mem[b] = diff;
        ref_pc     = taken ? c : ref_pc + 8'd3;
        if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        ref_halted = taken && (c == 8'hFF);
        check("pc", 32'(pc), 32'(ref_pc));
        check("icount", 32'(icount), 32'(ref_cnt));
        check("halted", 32'(halted), 32'(ref_halted));
        check("busy", 32'(busy), 32'(!(ref_halted || halt_req)));
        check("cycles", 32'(cyc - last_cyc), 32'(7 + 6 * w));
        last_cyc = cyc;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    // Start the program in ref_mem and retire until halted or stopped by halt_req.
    task automatic run(input int w, input int halt_after);
        int n = 0;
        int start_cyc;
        int mism = 0;
        bit done = 1'b0;
        for (int i = 0; i < 256; i++) dut_mem[i] = ref_mem[i];
        wait_cfg = w;
        rd_q.delete();
        wr_q.delete();
        ref_pc  = 8'h00;
        ref_cnt = 16'd0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        last_cyc  = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        check("halted_cleared", 32'(halted), 32'd0);
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_q.size() > 0) begin
                step(w);
                n++;
                if (ref_halted || halt_req) done = 1'b1;
            end
            if (!done && !halt_req && n >= halt_after && cyc - start_cyc >= 2) halt_req = 1'b1;
            if (!done && cyc - start_cyc == 3) start = 1'b1;
        end
        start    = 1'b0;
        halt_req = 1'b0;
        if (!done) check("run_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
        check("mem_image", 32'(mism), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pc", 32'(pc), 32'(ref_pc));
        check("idle_icount", 32'(icount), 32'(ref_cnt));
        check("idle_no_access", 32'(rd_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_icount", 32'(icount), 32'd0);
        @(negedge clk) rstn = 1'b1;

        // Equal operands: zero result branches to the halt address.
        clear_mem();
        ref_mem[0] = 8'h06; ref_mem[1] = 8'h07; ref_mem[2] = 8'hFF;
        ref_mem[6] = 8'h05; ref_mem[7] = 8'h05;
        run(0, 1000);
        check("t1_mem7", 32'(dut_mem[7]), 32'd0);
        check("t1_pc", 32'(pc), 32'hFF);
        run(3, 1000);

        // Positive result falls through to PC+3; halt_req stops after the next instruction.
        clear_mem();
        ref_mem[0] = 8'h06; ref_mem[1] = 8'h07; ref_mem[2] = 8'h20;
        ref_mem[6] = 8'h03; ref_mem[7] = 8'h05;
        run(1, 1);
        check("t2_mem7", 32'(dut_mem[7]), 32'd2);

        // Signed compare: 80-01 = 7F is positive, 00-01 = FF is negative.
        clear_mem();
        ref_mem[0]  = 8'h10; ref_mem[1]  = 8'h11; ref_mem[2]  = 8'h20;
        ref_mem[3]  = 8'h12; ref_mem[4]  = 8'h13; ref_mem[5]  = 8'h30;
        ref_mem[16] = 8'h01; ref_mem[17] = 8'h80;
        ref_mem[18] = 8'h01; ref_mem[19] = 8'h00;
        ref_mem[8'h30] = 8'h14; ref_mem[8'h31] = 8'h14; ref_mem[8'h32] = 8'hFF;
        run(0, 1000);
        check("t3_7f", 32'(dut_mem[17]), 32'h7F);
        check("t3_ff", 32'(dut_mem[19]), 32'hFF);

        // Instruction at FD wraps the fetch and the fall-through PC.
        clear_mem();
        ref_mem[0] = 8'h20; ref_mem[1] = 8'h20; ref_mem[2] = 8'hFD;
        ref_mem[8'hFD] = 8'h21; ref_mem[8'hFE] = 8'h22; ref_mem[8'hFF] = 8'h40;
        ref_mem[8'h21] = 8'h01; ref_mem[8'h22] = 8'h05;
        ref_mem[8'h40] = 8'h20; ref_mem[8'h41] = 8'h20; ref_mem[8'h42] = 8'hFF;
        run(2, 1000);

        // Random programs, wait states and halt points.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
        end

        // Reset while a write is pending in the second instruction.
        clear_mem();
        ref_mem[0]  = 8'h10; ref_mem[1]  = 8'h11; ref_mem[2]  = 8'h20;
        ref_mem[3]  = 8'h12; ref_mem[4]  = 8'h13; ref_mem[5]  = 8'h30;
        ref_mem[16] = 8'h01; ref_mem[17] = 8'h80;
        for (int i = 0; i < 256; i++) dut_mem[i] = ref_mem[i];
        wait_cfg = 3;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(posedge clk); #1;
                if (icount == 16'd1 && mem_req && mem_we) seen = 1'b1;
            end
            check("rst_wr_reached", 32'(seen), 32'd1);
        end
        #2 rstn = 1'b0;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_icount", 32'(icount), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk) rstn = 1'b1;
        check("midrst_mem", 32'(dut_mem[19]), 32'd0);

        // Recovery from reset.
        clear_mem();
        ref_mem[0] = 8'h06; ref_mem[1] = 8'h07; ref_mem[2] = 8'hFF;
        ref_mem[6] = 8'h09; ref_mem[7] = 8'h02;
        run(0, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
